// File: rtl/uart_rx_phy.sv
// UART receive PHY: 2-FF synchronised line, 16x oversampled start/data/parity/stop
// recovery with mid-bit sampling; delivers bytes and error flags as one-cycle strobes.
module uart_rx_phy #(
  parameter int OVS_DIV    = 54,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam int              TW       = (OVS_DIV > 2) ? $clog2(OVS_DIV) : 1;
  localparam logic [TW-1:0]   TICK_MAX = TW'(OVS_DIV - 1);
  localparam logic [TW-1:0]   TICK_ONE = TW'(1);
  localparam logic [TW-1:0]   TICK_ZERO = TW'(0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  function automatic logic parity_mismatch(input logic [7:0] data, input logic par_bit,
                                           input logic odd);
    return (^data) ^ par_bit ^ odd;
  endfunction

  state_t          state_r;
  logic            sync_meta_r;
  logic            rx_sync_r;
  logic [TW-1:0]   tick_cnt_r;
  logic [3:0]      sample_cnt_r;
  logic [2:0]      bit_cnt_r;
  logic [7:0]      shift_r;
  logic            parity_pend_r;

  logic            tick_s;
  logic            mid_start_s;
  logic            bit_end_s;

  assign tick_s      = (tick_cnt_r == TICK_MAX);
  assign mid_start_s = tick_s && (sample_cnt_r == 4'd7);
  assign bit_end_s   = tick_s && (sample_cnt_r == 4'd15);

  // Two-stage synchroniser for the asynchronous serial line; resets to the idle level.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      sync_meta_r <= 1'b1;
      rx_sync_r   <= 1'b1;
    end else begin
      sync_meta_r <= rx_in;
      rx_sync_r   <= sync_meta_r;
    end
  end

  // Receive FSM with oversampling counters, shift register and registered strobes.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_r       <= IDLE;
      tick_cnt_r    <= TICK_ZERO;
      sample_cnt_r  <= 4'd0;
      bit_cnt_r     <= 3'd0;
      shift_r       <= 8'h00;
      parity_pend_r <= 1'b0;
      rx_data       <= 8'h00;
      rx_valid      <= 1'b0;
      frame_err     <= 1'b0;
      parity_err    <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;

      // Counters are parked at zero in IDLE, which also aligns them to the start edge.
      if (state_r == IDLE) begin
        tick_cnt_r   <= TICK_ZERO;
        sample_cnt_r <= 4'd0;
      end else begin
        tick_cnt_r <= tick_s ? TICK_ZERO : (tick_cnt_r + TICK_ONE);
        if (tick_s) begin
          sample_cnt_r <= sample_cnt_r + 4'd1;
        end else begin
          sample_cnt_r <= sample_cnt_r;
        end
      end

      case (state_r)
        IDLE: begin
          if (!rx_sync_r) begin
            state_r       <= START;
            parity_pend_r <= 1'b0;
            rx_busy       <= 1'b1;
          end else begin
            rx_busy <= 1'b0;
          end
        end
        START: begin
          if (mid_start_s) begin
            if (rx_sync_r) begin
              state_r <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state_r      <= DATA;
              sample_cnt_r <= 4'd0;
              bit_cnt_r    <= 3'd0;
            end
          end
        end
        DATA: begin
          if (bit_end_s) begin
            shift_r   <= {rx_sync_r, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= PARITY_EN ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (bit_end_s) begin
            parity_pend_r <= parity_mismatch(shift_r, rx_sync_r, PARITY_ODD);
            state_r       <= STOP;
          end
        end
        STOP: begin
          // Leaving at mid stop bit leaves half a bit to catch a back-to-back start edge.
          if (bit_end_s) begin
            rx_data    <= shift_r;
            rx_valid   <= 1'b1;
            parity_err <= parity_pend_r;
            frame_err  <= ~rx_sync_r;
            if (rx_sync_r) begin
              state_r <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state_r <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rx_sync_r) begin
            state_r <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_phy.sv
// Self-checking bench for uart_rx_phy: a no-parity and an even-parity instance,
// table-driven frames, directed corner sequences and randomized frames vs. a frame-level model.
module tb_uart_rx_phy;

  localparam int OVS  = 4;
  localparam int BIT  = 16 * OVS;
  localparam bit PODD = 1'b0;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       line0   = 1'b1;
  logic       line1   = 1'b1;
  logic [7:0] rx_data0, rx_data1;
  logic       rx_valid0, rx_valid1;
  logic       frame_err0, frame_err1;
  logic       parity_err0, parity_err1;
  logic       rx_busy0, rx_busy1;

  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;
  bit     mon_en = 1'b0;
  longint last_cyc [2];
  longint prev_cyc [2];

  typedef struct {
    int         inst;
    longint     cyc;
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;
  exp_t expq[$];

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       pbit;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
    int         exp_lat;
  } vec_t;
  vec_t tbl [7];

  uart_rx_phy #(.OVS_DIV(OVS), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
    .sys_clk(sys_clk), .reset(reset), .rx_in(line0), .rx_data(rx_data0),
    .rx_valid(rx_valid0), .frame_err(frame_err0), .parity_err(parity_err0), .rx_busy(rx_busy0)
  );

  uart_rx_phy #(.OVS_DIV(OVS), .PARITY_EN(1'b1), .PARITY_ODD(PODD)) dut_par (
    .sys_clk(sys_clk), .reset(reset), .rx_in(line1), .rx_data(rx_data1),
    .rx_valid(rx_valid1), .frame_err(frame_err1), .parity_err(parity_err1), .rx_busy(rx_busy1)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Strobe monitor: every rx_valid must match the oldest outstanding expectation.
  task automatic mon(input int inst, input logic v, input logic [7:0] d, input logic fe,
                     input logic pe);
    exp_t e;
    if (v === 1'b1) begin
      prev_cyc[inst] = last_cyc[inst];
      last_cyc[inst] = cyc;
      if (expq.size() == 0) begin
        check($sformatf("spurious_valid%0d", inst), 64'(v), 64'd0);
      end else begin
        e = expq.pop_front();
        check($sformatf("valid_inst%0d", inst), 64'(inst), 64'(e.inst));
        check($sformatf("valid_cycle%0d", inst), 64'(cyc), 64'(e.cyc));
        check($sformatf("rx_data%0d", inst), 64'(d), 64'(e.data));
        check($sformatf("frame_err%0d", inst), 64'(fe), 64'(e.ferr));
        check($sformatf("parity_err%0d", inst), 64'(pe), 64'(e.perr));
      end
    end else if (v !== 1'b0 || fe !== 1'b0 || pe !== 1'b0) begin
      check($sformatf("idle_strobes%0d", inst), {61'd0, v, fe, pe}, 64'd0);
    end
  endtask

  always @(negedge sys_clk) if (mon_en) mon(0, rx_valid0, rx_data0, frame_err0, parity_err0);
  always @(negedge sys_clk) if (mon_en) mon(1, rx_valid1, rx_data1, frame_err1, parity_err1);

  task automatic drive(input int inst, input logic val, input int n);
    if (inst == 0) line0 = val;
    else line1 = val;
    repeat (n) @(negedge sys_clk);
  endtask

  // Sends one frame (instance 1 carries a parity bit); lat = rx_valid cycle after detect.
  task automatic send_frame(input int inst, input logic [7:0] data, input logic pbit,
                            input logic stop, input bit push, input logic [7:0] ed,
                            input logic ef, input logic ep, input int lat);
    exp_t e;
    if (push) begin
      e.inst = inst;
      e.cyc  = cyc + 2 + longint'(lat);
      e.data = ed;
      e.ferr = ef;
      e.perr = ep;
      expq.push_back(e);
    end
    drive(inst, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(inst, data[i], BIT);
    if (inst == 1) drive(inst, pbit, BIT);
    drive(inst, stop, BIT);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_data0"}, 64'(rx_data0), 64'd0);
    check({tag, "_flags0"}, {60'd0, rx_valid0, frame_err0, parity_err0, rx_busy0}, 64'd0);
    check({tag, "_data1"}, 64'(rx_data1), 64'd0);
    check({tag, "_flags1"}, {60'd0, rx_valid1, frame_err1, parity_err1, rx_busy1}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic       rs, rp, ef, ep;
    int         lat;

    tbl[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 609};
    tbl[1] = '{0, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 609};
    tbl[2] = '{0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 609};
    tbl[3] = '{1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 673};
    tbl[4] = '{1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 673};
    tbl[5] = '{1, 8'h55, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0, 673};
    tbl[6] = '{1, 8'h80, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 673};

    repeat (3) @(negedge sys_clk);
    check_reset_state("reset");
    reset  = 1'b0;
    mon_en = 1'b1;
    repeat (10) @(negedge sys_clk);

    for (int k = 0; k < 7; k++) begin
      send_frame(tbl[k].inst, tbl[k].data, tbl[k].pbit, tbl[k].stop, 1'b1,
                 tbl[k].exp_data, tbl[k].exp_ferr, tbl[k].exp_perr, tbl[k].exp_lat);
      drive(tbl[k].inst, 1'b1, 100);
      check($sformatf("busy_after_%0d", k),
            64'(tbl[k].inst == 0 ? rx_busy0 : rx_busy1), 64'd0);
    end

    // Glitch shorter than half a bit: rejected at mid start bit, nothing reported.
    drive(0, 1'b0, 2);
    check("glitch_busy_c0", 64'(rx_busy0), 64'd0);
    drive(0, 1'b0, 1);
    check("glitch_busy_c1", 64'(rx_busy0), 64'd1);
    drive(0, 1'b0, 13);
    drive(0, 1'b1, 18);
    check("glitch_busy_c32", 64'(rx_busy0), 64'd1);
    drive(0, 1'b1, 1);
    check("glitch_busy_c33", 64'(rx_busy0), 64'd0);
    drive(0, 1'b1, 50);
    check("data_hold", 64'(rx_data0), 64'h3C);
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 609);
    drive(0, 1'b1, 50);

    // Break: low stop bit, line held low; no restart until the line goes high.
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 609);
    drive(0, 1'b0, 640);
    check("break_busy_held", 64'(rx_busy0), 64'd1);
    drive(0, 1'b1, 2);
    check("break_busy_c2", 64'(rx_busy0), 64'd1);
    drive(0, 1'b1, 1);
    check("break_busy_released", 64'(rx_busy0), 64'd0);
    drive(0, 1'b1, 20);
    send_frame(0, 8'h81, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0, 609);
    drive(0, 1'b1, 50);

    // Back-to-back frames with a single stop bit.
    send_frame(0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 609);
    send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 609);
    drive(0, 1'b1, 100);
    check("b2b_spacing", 64'(last_cyc[0] - prev_cyc[0]), 64'd640);

    // One-cycle reset during data bit 4: partial frame dropped, outputs cleared.
    fork
      send_frame(0, 8'hF0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0);
      begin
        repeat (350) @(negedge sys_clk);
        check("pre_reset_busy", 64'(rx_busy0), 64'd1);
        reset = 1'b1;
        @(negedge sys_clk);
        check_reset_state("midframe_reset");
        reset = 1'b0;
      end
    join
    drive(0, 1'b1, 100);
    check("post_reset_idle", 64'(rx_busy0), 64'd0);
    send_frame(0, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 609);
    drive(0, 1'b1, 50);

    // Randomized frames against the frame-level model.
    for (int inst = 0; inst < 2; inst++) begin
      for (int i = 0; i < 15; i++) begin
        rd  = 8'($urandom_range(0, 255));
        rs  = ($urandom_range(0, 3) != 0);
        rp  = 1'($urandom_range(0, 1));
        ef  = ~rs;
        ep  = (inst == 1) ? ((($countones(rd) + int'(rp)) % 2) != int'(PODD)) : 1'b0;
        lat = 1 + (8 + 16 * (9 + inst)) * OVS;
        send_frame(inst, rd, rp, rs, 1'b1, rd, ef, ep, lat);
        if (rs) begin
          if ($urandom_range(0, 3) != 0) drive(inst, 1'b1, $urandom_range(1, 80));
        end else begin
          drive(inst, 1'b0, $urandom_range(0, 200));
          drive(inst, 1'b1, $urandom_range(2, 80));
        end
      end
      drive(inst, 1'b1, 100);
      check($sformatf("rand_busy_end%0d", inst),
            64'(inst == 0 ? rx_busy0 : rx_busy1), 64'd0);
    end

    repeat (100) @(negedge sys_clk);
    check("queue_drained", 64'(expq.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_phy.md
# uart_rx_phy

UART receiver PHY: recovers 8-bit frames from the asynchronous serial line at 16x oversampling, mid-bit sampling. Receive-side counterpart of the TX MAC/PHY path; runs on the same system clock and baud parameterisation, delivering bytes plus error flags to the RX MAC as one-cycle strobes.

## Interface
- OVS_DIV, 54: sys_clk cycles per oversample tick (1/16 bit); ≥2. 54 ≈ 57600 bps at 50 MHz.
- PARITY_EN, 0: 1 = a parity bit follows the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.

- sys_clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- rx_in  in  1  asynchronous serial line; idle high.
- rx_data  out  8  last received byte, LSB received first; holds until the next frame completes.
- rx_valid  out  1  one-cycle strobe: rx_data updated.
- frame_err  out  1  one-cycle strobe with rx_valid: stop bit sampled 0.
- parity_err  out  1  one-cycle strobe with rx_valid: parity mismatch.
- rx_busy  out  1  high in every state except IDLE.

## Operation
- rx_in passes a 2-FF synchronizer (both FFs reset to 1); all logic uses the synchronized bit rx_s.
- Tick counter: $clog2(OVS_DIV) bits, counts 0..OVS_DIV-1 and wraps; tick = 1 when count = OVS_DIV-1. Cleared to 0 on start detect.
- Sample counter: 4 bits, counts ticks within a bit and wraps 15→0. Bit counter: 3 bits.
- States:
  - IDLE: rx_s = 0 → START; tick and sample counters cleared.
  - START: on the 8th tick (mid start bit) sample rx_s. 1 → IDLE (false start, nothing reported). 0 → DATA; sample and bit counters cleared.
  - DATA: every 16th tick sample rx_s into shift register, LSB first. After bit 7 → PARITY if PARITY_EN, else STOP.
  - PARITY: sample on the 16th tick; parity_err_pending = (XOR of data ^ sampled bit ^ PARITY_ODD) ≠ 0. → STOP.
  - STOP: sample on the 16th tick. Next cycle: rx_data ← shift register, rx_valid = 1, parity_err = pending, frame_err = !sample. Sample 1 → IDLE. Sample 0 → BREAK.
  - BREAK: wait until rx_s = 1, then → IDLE. A low line never starts a new frame.
- Strobes are registered, high for exactly one cycle, and 0 at all other times.
- An errored frame still delivers rx_data and rx_valid.
- Returning to IDLE at mid stop bit allows a back-to-back start edge at the end of the stop bit.
- Reset (any state, mid-frame included): state IDLE; rx_data 0x00; rx_valid, frame_err, parity_err, rx_busy 0; counters 0; synchronizer 1. Partial frame discarded; no strobe.

## Timing
- Cycle 0 = first cycle IDLE sees rx_s = 0; rx_s lags rx_in by 2 cycles.
- Tick k occurs at cycle k·OVS_DIV.
- Start sample at tick 8. Data bit n (0..7) sampled at tick 8+16·(n+1). Parity at tick 152. Stop at tick 152, or 168 with parity.
- rx_valid at stop-sample cycle + 1 = 152·OVS_DIV + 1, or 168·OVS_DIV + 1 with parity.
- rx_busy rises at cycle 1 and falls the cycle after leaving STOP, BREAK or START.
- Tolerates ±3% baud mismatch for a 10-bit frame.
- Throughput: one byte per frame time; no backpressure. The consumer captures on rx_valid.

## Test plan
OVS_DIV = 4 (bit period 64 cycles) unless stated.
- Frame 0xA5, PARITY_EN=0, stop=1 → rx_valid once at cycle 609 after detect; rx_data = 0xA5; frame_err = parity_err = 0; rx_busy low afterwards.
- Glitch: rx_in low 16 cycles, then high → no rx_valid; START rejects at tick 8; rx_busy high then low; next valid frame 0x5A received correctly.
- Frame 0x3C with stop = 0, line held low a further 640 cycles → rx_valid with rx_data = 0x3C and frame_err = 1; no further strobes until the line returns high; then frame 0x81 is received cleanly.
- PARITY_EN=1, PARITY_ODD=0. Frame 0x07 with parity bit 0 → parity_err = 1 at cycle 673. Same frame with parity bit 1 → parity_err = 0.
- Back-to-back 0x00 then 0xFF, one stop bit each → two rx_valid pulses exactly 640 cycles apart; data correct; no errors.
- Assert reset for one cycle during data bit 4 → all outputs 0 next cycle, no strobe; the following frame 0xC3 is received with no errors.
